// File: rtl/i2c_slave_regfile.sv
// I2C target bridging bus transfers onto a byte-wide register file strobe interface.
// The pointer is set by the first written byte and auto-increments with wrap-around.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = 8,
    parameter int         FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_wr_en,
    output logic             reg_rd_en,
    input  logic [7:0]       reg_rdata,
    output logic             selected,
    output logic             stop_det
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t           r_state, w_next;
    logic [1:0]       w_pin;
    logic [1:0]       r_meta, r_sync, r_filt, r_filt_d;
    logic [3:0]       r_fcnt [2];
    logic             w_scl_rise, w_scl_fall, w_start, w_stop, w_last;
    logic             w_addr_hit, w_ptr_ok;
    logic [7:0]       w_byte;
    logic [6:0]       r_rx;
    logic [2:0]       r_bit;
    logic [7:0]       r_tx;
    logic [PTR_W-1:0] r_ptr, w_ptr_inc;
    logic             r_rw, r_ack_on, r_rd_pend, r_drv_pend;

    // Index 0 carries SCL, index 1 carries SDA through synchroniser and filter
    assign w_pin = {sda_in, scl_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta    <= 2'b11;
            r_sync    <= 2'b11;
            r_filt    <= 2'b11;
            r_filt_d  <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_meta   <= w_pin;
            r_sync   <= r_meta;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == 4'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 4'd1;
                end
            end
        end
    end

    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    assign w_start    = r_filt[0] & r_filt_d[0] & r_filt_d[1] & ~r_filt[1];
    assign w_stop     = r_filt[0] & r_filt_d[0] & ~r_filt_d[1] & r_filt[1];
    assign w_byte     = {r_rx, r_filt[1]};
    assign w_last     = w_scl_rise && (r_bit == 3'd7);
    assign w_addr_hit = (w_byte[7:1] == SLAVE_ADDR);
    assign w_ptr_ok   = ({1'b0, w_byte} < 9'(NUM_REGS));
    assign w_ptr_inc  = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // ACK states span two falling edges: the first drives the ACK bit, the second ends it
    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = ST_ADDR;
        end else if (w_stop) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR:     if (w_last) w_next = w_addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: if (w_scl_fall && r_ack_on) w_next = r_rw ? ST_RD_DATA : ST_PTR;
                ST_PTR:      if (w_last) w_next = w_ptr_ok ? ST_PTR_ACK : ST_IGNORE;
                ST_PTR_ACK:  if (w_scl_fall && r_ack_on) w_next = ST_WR_DATA;
                ST_WR_DATA:  if (w_last) w_next = ST_WR_ACK;
                ST_WR_ACK:   if (w_scl_fall && r_ack_on) w_next = ST_WR_DATA;
                ST_RD_DATA:  if (w_last) w_next = ST_RD_ACK;
                ST_RD_ACK: begin
                    if (w_scl_rise && r_ack_on && r_filt[1]) w_next = ST_IGNORE;
                    else if (w_scl_fall && r_ack_on)         w_next = ST_RD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            selected   <= 1'b0;
            stop_det   <= 1'b0;
            r_rx       <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_ack_on   <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_drv_pend <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            stop_det  <= 1'b0;
            r_rd_pend <= reg_rd_en;
            // Read data arrives one clk after the strobe; mid-read bytes are driven as soon as captured
            if (r_rd_pend) begin
                if (r_drv_pend) begin
                    sda_oe     <= ~reg_rdata[7];
                    r_tx       <= {reg_rdata[6:0], 1'b1};
                    r_drv_pend <= 1'b0;
                end else begin
                    r_tx <= reg_rdata;
                end
            end
            if (w_start) begin
                r_bit      <= '0;
                r_ack_on   <= 1'b0;
                r_drv_pend <= 1'b0;
                sda_oe     <= 1'b0;
            end else if (w_stop) begin
                r_bit      <= '0;
                r_ack_on   <= 1'b0;
                r_drv_pend <= 1'b0;
                sda_oe     <= 1'b0;
                selected   <= 1'b0;
                stop_det   <= 1'b1;
            end else begin
                if (w_scl_rise) begin
                    r_rx  <= w_byte[6:0];
                    r_bit <= r_bit + 3'd1;
                end
                case (r_state)
                    ST_ADDR: if (w_last) begin
                        r_rw     <= w_byte[0];
                        selected <= w_addr_hit;
                    end
                    ST_ADDR_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            sda_oe   <= 1'b1;
                            r_ack_on <= 1'b1;
                            if (r_rw) begin
                                reg_rd_en <= 1'b1;
                                reg_addr  <= r_ptr;
                                r_ptr     <= w_ptr_inc;
                            end
                        end else begin
                            r_ack_on <= 1'b0;
                            r_bit    <= '0;
                            if (r_rw) begin
                                sda_oe <= ~r_tx[7];
                                r_tx   <= {r_tx[6:0], 1'b1};
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_PTR: if (w_last && w_ptr_ok) r_ptr <= PTR_W'(w_byte);
                    ST_PTR_ACK, ST_WR_ACK: if (w_scl_fall) begin
                        sda_oe   <= ~r_ack_on;
                        r_ack_on <= ~r_ack_on;
                        if (r_ack_on) r_bit <= '0;
                    end
                    ST_WR_DATA: if (w_last) begin
                        reg_wr_en <= 1'b1;
                        reg_addr  <= r_ptr;
                        reg_wdata <= w_byte;
                        r_ptr     <= w_ptr_inc;
                    end
                    ST_RD_DATA: if (w_scl_fall) begin
                        sda_oe <= ~r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b1};
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise && r_ack_on && r_filt[1]) begin
                            r_ack_on <= 1'b0;
                        end else if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                sda_oe   <= 1'b0;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_ack_on   <= 1'b0;
                                r_bit      <= '0;
                                reg_rd_en  <= 1'b1;
                                reg_addr   <= r_ptr;
                                r_ptr      <= w_ptr_inc;
                                r_drv_pend <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master and a register-file read model.
module tb_i2c_slave_regfile;

    localparam int Q = 10;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_in, sda_in;
    logic       sda_oe, reg_wr_en, reg_rd_en, selected, stop_det;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] mem [256];

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_stop = 0;
    bit         oe_seen = 0;
    bit         sel_seen = 0;
    bit         both_seen = 0;
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] rd_addr_q[$];

    // Open-drain bus: the line is low if either side pulls it
    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .SLAVE_ADDR(7'h42), .NUM_REGS(16), .PTR_W(8), .FILTER_LEN(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .selected(selected), .stop_det(stop_det)
    );

    always @(posedge clk) if (reg_rd_en) reg_rdata <= mem[reg_addr];

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (reg_rd_en) rd_addr_q.push_back(reg_addr);
        if (stop_det) n_stop++;
        if (sda_oe) oe_seen = 1'b1;
        if (selected) sel_seen = 1'b1;
        if (reg_wr_en && reg_rd_en) both_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic hc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hc(Q);
        m_scl = 1'b1; hc(H);
        m_sda = 1'b0; hc(H);
        m_scl = 1'b0; hc(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hc(Q);
        m_scl = 1'b1; hc(H);
        m_sda = 1'b1; hc(H);
    endtask

    // gbit selects a bit that receives a short SCL pulse while low and an SDA pulse while high
    task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            if (i == gbit) begin
                hc(3); m_scl = 1'b1; hc(2); m_scl = 1'b0; hc(Q - 5);
            end else begin
                hc(Q);
            end
            m_scl = 1'b1;
            if (i == gbit) begin
                hc(5); m_sda = ~m_sda; hc(2); m_sda = ~m_sda; hc(H - 7);
            end else begin
                hc(H);
            end
            m_scl = 1'b0; hc(Q);
        end
        m_sda = 1'b1; hc(Q);
        m_scl = 1'b1; hc(H / 2);
        ack = sda_in;
        hc(H / 2);
        m_scl = 1'b0; hc(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        b = 8'h00;
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hc(Q);
            m_scl = 1'b1; hc(H / 2);
            b = {b[6:0], sda_in};
            hc(H / 2);
            m_scl = 1'b0; hc(Q);
        end
        m_sda = nack; hc(Q);
        m_scl = 1'b1; hc(H);
        m_scl = 1'b0; hc(Q);
        m_sda = 1'b1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        oe_seen  = 1'b0;
        sel_seen = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         s0;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
        hc(5);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_selected", selected, 0);
        check_val("rst_strobes", {reg_wr_en, reg_rd_en, stop_det}, 0);
        check_val("rst_addr_wdata", {reg_addr, reg_wdata}, 0);
        rst_n = 1'b1;
        hc(10);

        // Register write: two bytes from pointer 3
        clear_logs(); s0 = n_stop;
        i2c_start();
        write_byte(8'h84, -1, ack); check_val("wr_addr_ack", ack, 0);
        write_byte(8'h03, -1, ack); check_val("wr_ptr_ack", ack, 0);
        write_byte(8'hAA, -1, ack); check_val("wr_d0_ack", ack, 0);
        write_byte(8'h55, -1, ack); check_val("wr_d1_ack", ack, 0);
        check_val("wr_selected", selected, 1);
        i2c_stop(); hc(10);
        check_val("wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check_val("wr0", {wr_addr_q[0], wr_data_q[0]}, 16'h03AA);
            check_val("wr1", {wr_addr_q[1], wr_data_q[1]}, 16'h0455);
        end
        check_val("wr_stop_cnt", n_stop - s0, 1);
        check_val("wr_sel_after_stop", selected, 0);

        // Pointer 15, repeated START, read two bytes across the wrap
        mem[15] = 8'h11; mem[0] = 8'h22;
        clear_logs();
        i2c_start();
        write_byte(8'h84, -1, ack); check_val("rd_waddr_ack", ack, 0);
        write_byte(8'h0F, -1, ack); check_val("rd_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h85, -1, ack); check_val("rd_raddr_ack", ack, 0);
        read_byte(1'b0, rb); check_val("rd_byte0", rb, 8'h11);
        read_byte(1'b1, rb); check_val("rd_byte1", rb, 8'h22);
        i2c_stop(); hc(10);
        check_val("rd_count", rd_addr_q.size(), 2);
        if (rd_addr_q.size() == 2) begin
            check_val("rd_addr0", rd_addr_q[0], 8'h0F);
            check_val("rd_addr1", rd_addr_q[1], 8'h00);
        end
        check_val("rd_no_wr", wr_addr_q.size(), 0);

        // Wrong address: no ACK, no strobes, never selected
        clear_logs();
        i2c_start();
        write_byte(8'h86, -1, ack); check_val("wa_nack", ack, 1);
        write_byte(8'h12, -1, ack); check_val("wa_data_nack", ack, 1);
        i2c_stop(); hc(10);
        check_val("wa_oe_seen", oe_seen, 0);
        check_val("wa_sel_seen", sel_seen, 0);
        check_val("wa_strobes", wr_addr_q.size() + rd_addr_q.size(), 0);

        // Out-of-range pointer: NACK, no write, pointer stays at 1
        mem[1] = 8'h3C;
        clear_logs();
        i2c_start();
        write_byte(8'h84, -1, ack); check_val("oor_addr_ack", ack, 0);
        write_byte(8'h10, -1, ack); check_val("oor_ptr_nack", ack, 1);
        write_byte(8'h99, -1, ack); check_val("oor_data_nack", ack, 1);
        i2c_stop(); hc(10);
        check_val("oor_no_wr", wr_addr_q.size(), 0);
        i2c_start();
        write_byte(8'h85, -1, ack); check_val("oor_raddr_ack", ack, 0);
        read_byte(1'b1, rb); check_val("oor_rd_data", rb, 8'h3C);
        i2c_stop(); hc(10);
        check_val("oor_rd_count", rd_addr_q.size(), 1);
        if (rd_addr_q.size() == 1) check_val("oor_rd_addr", rd_addr_q[0], 8'h01);

        // Glitches in IDLE, then inside a pointer byte
        clear_logs(); s0 = n_stop;
        m_sda = 1'b0; hc(2); m_sda = 1'b1; hc(10);
        m_scl = 1'b0; hc(2); m_scl = 1'b1; hc(10);
        check_val("gl_idle_sel", sel_seen, 0);
        check_val("gl_idle_stop", n_stop - s0, 0);
        check_val("gl_idle_oe", oe_seen, 0);
        i2c_start();
        write_byte(8'h84, -1, ack); check_val("gl_addr_ack", ack, 0);
        write_byte(8'h05, 2, ack);  check_val("gl_ptr_ack", ack, 0);
        write_byte(8'h77, -1, ack); check_val("gl_data_ack", ack, 0);
        i2c_stop(); hc(10);
        check_val("gl_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) check_val("gl_wr", {wr_addr_q[0], wr_data_q[0]}, 16'h0577);
        check_val("gl_stop_cnt", n_stop - s0, 1);

        // Reset asserted while the target drives a 0 data bit
        mem[0] = 8'h00;
        clear_logs();
        i2c_start();
        write_byte(8'h84, -1, ack); check_val("rs_addr_ack", ack, 0);
        write_byte(8'h00, -1, ack); check_val("rs_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h85, -1, ack); check_val("rs_raddr_ack", ack, 0);
        hc(2);
        check_val("rs_pre_oe", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rs_async_oe", sda_oe, 0);
        check_val("rs_async_sel", selected, 0);
        m_sda = 1'b1; hc(2); m_scl = 1'b1; hc(10);
        rst_n = 1'b1; hc(10);
        clear_logs();
        i2c_start();
        write_byte(8'h85, -1, ack); check_val("rs_new_ack", ack, 0);
        read_byte(1'b1, rb); check_val("rs_new_data", rb, 8'h00);
        i2c_stop(); hc(10);
        check_val("rs_rd_count", rd_addr_q.size(), 1);
        if (rd_addr_q.size() == 1) check_val("rs_ptr_zero", rd_addr_q[0], 8'h00);

        check_val("strobe_excl", both_seen, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
